// File: rtl/boot_mode_ctrl.sv
// Boot-mode controller: debounced start button switches between CPU run mode and
// UART programming mode, routes programmer writes to imem/dmem and counts them.
module boot_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic        fpga_clk,
  input  logic        fpga_rst_n,
  input  logic        start,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_addr_i,
  input  logic        upg_done_i,
  output logic        upg_rst_o,
  output logic        cpu_rst_o,
  output logic        imem_wen_o,
  output logic        dmem_wen_o,
  output logic [1:0]  mode_o,
  output logic [15:0] prog_words_o
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    PROG = 2'b01,
    DONE = 2'b10
  } state_e;

  logic              s1_q, s2_q;
  logic              deb_q, deb_d;
  logic              deb_prev_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  state_e            state_q, state_d;
  logic              upg_rst_q, upg_rst_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [15:0]       prog_words_q, prog_words_d;
  logic              start_pulse;
  logic              in_prog;
  logic              wr_any;
  logic              unused_addr;

  assign unused_addr = ^upg_addr_i[13:0];

  // The counter only runs while the synchronised level disagrees with deb.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (s2_q != deb_q) begin
      if (deb_cnt_q == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
        deb_d = s2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  assign start_pulse = deb_q & ~deb_prev_q;

  // Gating with reset keeps an aborted session from issuing one last write.
  assign in_prog    = (state_q == PROG) & fpga_rst_n;
  assign imem_wen_o = upg_wen_i & ~upg_addr_i[14] & in_prog;
  assign dmem_wen_o = upg_wen_i &  upg_addr_i[14] & in_prog;
  assign wr_any     = imem_wen_o | dmem_wen_o;

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    prog_words_d = prog_words_q;
    case (state_q)
      RUN: begin
        if (start_pulse) begin
          state_d      = PROG;
          prog_words_d = '0;
        end
      end
      PROG: begin
        if (wr_any && (prog_words_q != 16'hFFFF)) begin
          prog_words_d = prog_words_q + 16'd1;
        end
        if (upg_done_i) begin
          state_d    = DONE;
          hold_cnt_d = '0;
        end
      end
      DONE: begin
        if (hold_cnt_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
    upg_rst_d = (state_d == RUN);
    cpu_rst_d = (state_d != RUN);
  end

  always_ff @(posedge fpga_clk) begin
    if (!fpga_rst_n) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      deb_q        <= 1'b0;
      deb_prev_q   <= 1'b0;
      deb_cnt_q    <= '0;
      hold_cnt_q   <= '0;
      state_q      <= RUN;
      upg_rst_q    <= 1'b1;
      cpu_rst_q    <= 1'b0;
      prog_words_q <= '0;
    end else begin
      s1_q         <= start;
      s2_q         <= s1_q;
      deb_q        <= deb_d;
      deb_prev_q   <= deb_q;
      deb_cnt_q    <= deb_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      state_q      <= state_d;
      upg_rst_q    <= upg_rst_d;
      cpu_rst_q    <= cpu_rst_d;
      prog_words_q <= prog_words_d;
    end
  end

  assign mode_o       = state_q;
  assign prog_words_o = prog_words_q;
  assign upg_rst_o    = upg_rst_q | ~fpga_rst_n;
  assign cpu_rst_o    = cpu_rst_q | ~fpga_rst_n;

endmodule

// File: tb/tb_boot_mode_ctrl.sv
// Scoreboard bench for boot_mode_ctrl: a cycle-level reference model predicts each
// cycle's outputs into a queue, and a negedge monitor compares them with the DUT.
`timescale 1ns/1ps
module tb_boot_mode_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        upg_wen;
  logic [14:0] upg_addr;
  logic        upg_done;
  logic        upg_rst, cpu_rst, imem_wen, dmem_wen;
  logic [1:0]  mode;
  logic [15:0] prog_words;

  boot_mode_ctrl #(.DEBOUNCE_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .fpga_clk    (clk),
    .fpga_rst_n  (rst_n),
    .start       (start),
    .upg_wen_i   (upg_wen),
    .upg_addr_i  (upg_addr),
    .upg_done_i  (upg_done),
    .upg_rst_o   (upg_rst),
    .cpu_rst_o   (cpu_rst),
    .imem_wen_o  (imem_wen),
    .dmem_wen_o  (dmem_wen),
    .mode_o      (mode),
    .prog_words_o(prog_words)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] words;
    logic        imem;
    logic        dmem;
    logic        cpu_rst;
    logic        upg_rst;
  } exp_t;

  exp_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Reference model state: mode 0=RUN 1=PROG 2=DONE; the debounce is modelled as
  // "the last DEB synchronised samples all disagree with the accepted level".
  int   m_mode      = 0;
  int   m_words     = 0;
  int   m_done_left = 0;
  bit   m_s1 = 0, m_s2 = 0, m_deb = 0, m_deb_prev = 0;
  bit   m_hist[$];

  task automatic modelEdge();
    bit pulse, s2_old, all_diff;
    if (!rst_n) begin
      m_mode = 0; m_words = 0; m_done_left = 0;
      m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_prev = 0;
      m_hist.delete();
      return;
    end
    pulse = m_deb && !m_deb_prev;
    case (m_mode)
      0: if (pulse) begin m_mode = 1; m_words = 0; end
      1: begin
        if (upg_wen && m_words < 65535) m_words++;
        if (upg_done) begin m_mode = 2; m_done_left = HOLD; end
      end
      default: begin
        m_done_left--;
        if (m_done_left == 0) m_mode = 0;
      end
    endcase
    s2_old = m_s2;
    m_deb_prev = m_deb;
    m_hist.push_back(s2_old);
    if (m_hist.size() > DEB) void'(m_hist.pop_front());
    if (m_hist.size() == DEB) begin
      all_diff = 1;
      foreach (m_hist[i]) if (m_hist[i] == m_deb) all_diff = 0;
      if (all_diff) m_deb = s2_old;
    end
    m_s2 = m_s1;
    m_s1 = start;
  endtask

  // Drive one cycle of inputs, predict this cycle's outputs, then advance the model.
  task automatic applyStimulus(input logic r, input logic s, input logic w,
                               input logic [14:0] a, input logic d);
    exp_t e;
    rst_n = r; start = s; upg_wen = w; upg_addr = a; upg_done = d;
    e.mode    = 2'(m_mode);
    e.words   = 16'(m_words);
    e.imem    = r && m_mode == 1 && w && !a[14];
    e.dmem    = r && m_mode == 1 && w &&  a[14];
    e.cpu_rst = !r || m_mode != 0;
    e.upg_rst = !r || m_mode == 0;
    sb_q.push_back(e);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      if (miscompares <= 40)
        $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        vectors++;
        checkOutput("mode_o",       16'(mode),     16'(e.mode));
        checkOutput("prog_words_o", prog_words,    e.words);
        checkOutput("imem_wen_o",   16'(imem_wen), 16'(e.imem));
        checkOutput("dmem_wen_o",   16'(dmem_wen), 16'(e.dmem));
        checkOutput("cpu_rst_o",    16'(cpu_rst),  16'(e.cpu_rst));
        checkOutput("upg_rst_o",    16'(upg_rst),  16'(e.upg_rst));
      end
    end
  end

  initial begin : watchdog
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int n, input logic s);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, s, 1'b0, 15'(i), 1'b0);
  endtask

  initial begin : stimulus
    logic s_lvl;
    int   hold_len;
    rst_n = 1'b0; start = 1'b0; upg_wen = 1'b0; upg_addr = '0; upg_done = 1'b0;
    @(posedge clk);
    modelEdge();
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, 15'h0004, 1'b1);

    // Glitch of 3 cycles must be swallowed, then a real press enters PROG.
    idle(3, 1'b1);
    idle(10, 1'b0);
    idle(12, 1'b1);

    // Routing of one imem and one dmem write, then write+done together.
    applyStimulus(1'b1, 1'b1, 1'b1, 15'h0004, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 15'h4010, 1'b0);
    idle(2, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 15'h0100, 1'b1);
    idle(12, 1'b1);

    // Release, press again, then abort mid-session with a write pending.
    idle(8, 1'b0);
    idle(10, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b1, 15'($urandom), 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 15'h4000, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b1, 15'($urandom), 1'b0);

    // Random button bounce, writes, done strobes and occasional resets.
    s_lvl = 1'b0;
    for (int i = 0; i < 60; i++) begin
      hold_len = $urandom_range(1, 9);
      s_lvl = ~s_lvl;
      for (int j = 0; j < hold_len; j++)
        applyStimulus(($urandom % 100) != 0, s_lvl, 1'($urandom), 15'($urandom),
                      ($urandom % 12) == 0);
    end

    // Saturation: 65537 writes in a single session.
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 15'h0, 1'b0);
    idle(8, 1'b0);
    idle(10, 1'b1);
    for (int i = 0; i < 65537; i++) applyStimulus(1'b1, 1'b1, 1'b1, 15'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 15'h4ABC, 1'b1);
    idle(12, 1'b1);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard: %0d entries left, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
